// File: rtl/iref_sweep_pkg.sv
// iref_sweep_pkg: shared types and constant helpers for the i_ref sweep controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sweep_state_t (controller FSM states), sat_max() (all-ones value of a width).
package iref_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    WAIT    = 3'd3,
    EVAL    = 3'd4,
    DONE    = 3'd5,
    FAIL    = 3'd6
  } sweep_state_t;

  // Largest unsigned value representable in w bits; used as the saturation
  // ceiling for i_ref and for the back-off operating point.
  function automatic logic [31:0] sat_max(input int w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/iref_sweep_ctrl_sweep_timer.sv
// sweep_timer: loadable down-counter with a zero flag (settle delay and WAIT watchdog).
// Latency: load takes effect on the next clk edge; zero is combinational from the count.
// Backpressure: none; dec is ignored once the count reaches zero (no wrap).
// Ports: clk, rst (async, active-high), load/load_val (load wins over dec), dec, zero.
module sweep_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/iref_sweep_ctrl.sv
// iref_sweep_ctrl: steps the DAC bias i_ref down from full scale, measures Q at each point,
//   and picks an operating point BACKOFF_STEPS above the first point where Q jumps by > DELTA.
// Latency: SETTLE_CYCLES + 1 + (measurement time) + 1 cycles per sweep point.
// Backpressure: start ignored while busy; abort cancels from any state; meas_done only heard in WAIT.
// Ports: clk, rst (async, active-high), start, abort, meas_start/meas_done/q_measured
//   (measurement handshake), i_ref (DAC code), i_ref_opt (chosen point), busy/found/fail/timeout.
// Option: define IREF_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT_CYCLES); otherwise
//   WAIT waits indefinitely and timeout is tied low.
module iref_sweep_ctrl
  import iref_sweep_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int DELTA          = 300,
  parameter int IREF_STEP      = 50,
  parameter int SETTLE_CYCLES  = 16,
  parameter int BACKOFF_STEPS  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             meas_start,
  input  logic             meas_done,
  input  logic [WIDTH-1:0] q_measured,
  output logic [WIDTH-1:0] i_ref,
  output logic [WIDTH-1:0] i_ref_opt,
  output logic             busy,
  output logic             found,
  output logic             fail,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] IMAX     = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] IREF_DEC = WIDTH'(IREF_STEP);
  localparam int               TMAX     = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                           : TIMEOUT_CYCLES;
  localparam int               CW       = $clog2(TMAX + 1);
  // Timer is loaded with N-1 so the owning state lasts exactly N cycles.
  localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]    TMO_LOAD    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      BACKOFF_AMT = 32'(BACKOFF_STEPS * IREF_STEP);

  sweep_state_t     state;
  sweep_state_t     next_state;
  logic [WIDTH-1:0] i_ref_q;
  logic [WIDTH-1:0] i_ref_opt_q;
  logic [WIDTH-1:0] curr_q;
  logic [WIDTH-1:0] last_q;
  logic             first_pt;

  logic             tmr_load;
  logic [CW-1:0]    tmr_load_val;
  logic             tmr_dec;
  logic             tmr_zero;

  // One extra bit keeps the difference honest: a Q drop yields a large value
  // here, but the curr_q > last_q term rejects it before it can count.
  logic [WIDTH:0]   q_rise;
  logic             unstable;
  logic             iref_low;
  logic [31:0]      backoff_sum;
  logic [WIDTH-1:0] opt_sat;

  assign q_rise      = {1'b0, curr_q} - {1'b0, last_q};
  assign unstable    = !first_pt && (curr_q > last_q) && (32'(q_rise) > 32'(DELTA));
  assign iref_low    = 32'(i_ref_q) < 32'(IREF_STEP);
  // Sum formed in 32 bits so the back-off cannot wrap before saturation.
  assign backoff_sum = 32'(i_ref_q) + BACKOFF_AMT;
  assign opt_sat     = (backoff_sum > 32'(IMAX)) ? IMAX : backoff_sum[WIDTH-1:0];

  sweep_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort outranks every other input.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE, FAIL: if (start) next_state = SETTLE;
        SETTLE:           if (tmr_zero) next_state = MEASURE;
        MEASURE:          next_state = WAIT;
        WAIT: begin
          if (meas_done) begin
            next_state = EVAL;
          end
`ifdef IREF_TIMEOUT_EN
          else if (tmr_zero) begin
            next_state = FAIL;
          end
`endif
        end
        EVAL: begin
          if (unstable) begin
            next_state = DONE;
          end else if (iref_low) begin
            next_state = FAIL;
          end else begin
            next_state = SETTLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Output and timer-control decode
  always_comb begin
    meas_start   = (state == MEASURE);
    busy         = (state == SETTLE) || (state == MEASURE) || (state == WAIT) || (state == EVAL);
    found        = (state == DONE);
    fail         = (state == FAIL);
    // Settle count loads on every entry to SETTLE; the watchdog loads while
    // MEASURE so it is armed on the first WAIT cycle.
    tmr_load     = ((next_state == SETTLE) && (state != SETTLE)) || (state == MEASURE);
    tmr_load_val = (state == MEASURE) ? TMO_LOAD : SETTLE_LOAD;
    tmr_dec      = (state == SETTLE) || (state == WAIT);
  end

  // Sweep datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_ref_q     <= IMAX;
      i_ref_opt_q <= '0;
      curr_q      <= '0;
      last_q      <= '0;
      first_pt    <= 1'b0;
    end else if (abort) begin
      i_ref_q     <= IMAX;
      i_ref_opt_q <= '0;
      curr_q      <= '0;
      last_q      <= '0;
      first_pt    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            i_ref_q  <= IMAX;
            first_pt <= 1'b1;
          end
        end
        WAIT: begin
          if (meas_done) begin
            last_q <= curr_q;
            curr_q <= q_measured;
          end
        end
        EVAL: begin
          if (unstable) begin
            i_ref_opt_q <= opt_sat;
          end else if (!iref_low) begin
            i_ref_q  <= i_ref_q - IREF_DEC;
            first_pt <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign i_ref     = i_ref_q;
  assign i_ref_opt = i_ref_opt_q;

`ifdef IREF_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (abort) begin
      timeout_q <= 1'b0;
    end else if (((state == IDLE) || (state == DONE) || (state == FAIL)) && start) begin
      timeout_q <= 1'b0;
    end else if ((state == WAIT) && !meas_done && tmr_zero) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_iref_sweep_ctrl.sv
// tb_iref_sweep_ctrl: directed scenarios plus randomized start/abort/Q traffic for iref_sweep_ctrl,
//   compared every cycle against a point-by-point behavioural model of the sweep.
// Honours IREF_TIMEOUT_EN the same way the design does.
module tb_iref_sweep_ctrl;

  localparam int W       = 10;
  localparam int DELTA   = 300;
  localparam int STEP    = 50;
  localparam int SETTLE  = 4;
  localparam int BACKOFF = 2;
  localparam int TMO     = 32;
  localparam int IMAX    = 1023;
`ifdef IREF_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic         meas_start;
  logic         meas_done;
  logic [W-1:0] q_measured;
  logic [W-1:0] i_ref;
  logic [W-1:0] i_ref_opt;
  logic         busy;
  logic         found;
  logic         fail;
  logic         timeout;

  iref_sweep_ctrl #(
    .WIDTH(W), .DELTA(DELTA), .IREF_STEP(STEP), .SETTLE_CYCLES(SETTLE),
    .BACKOFF_STEPS(BACKOFF), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .meas_start(meas_start), .meas_done(meas_done), .q_measured(q_measured),
    .i_ref(i_ref), .i_ref_opt(i_ref_opt), .busy(busy), .found(found),
    .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- measurement responder ----------------
  int  qmode   = 0;
  bit  resp_en = 1'b1;
  bit  spur_en = 1'b0;
  int  dly_lo  = 0;
  int  dly_hi  = 4;

  // Q as a function of the bias code for each scenario.
  function automatic logic [W-1:0] qfunc(input int mode, input int ir);
    case (mode)
      0:       return (ir >= 523) ? 10'd100 : 10'd500;
      1:       return 10'(100 + (ir * 500) / 1023);
      2:       return (ir >= 523) ? 10'd100 : 10'd400;
      3:       return (ir >= 1000) ? 10'd100 : 10'd401;
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    bit           pend = 1'b0;
    int           pdly = 0;
    logic [W-1:0] pq   = '0;
    meas_done  = 1'b0;
    q_measured = '0;
    forever begin
      @(negedge clk);
      meas_done = 1'b0;
      if (pend) begin
        if (pdly == 0) begin
          meas_done  = 1'b1;
          q_measured = pq;
          pend       = 1'b0;
        end else begin
          pdly--;
        end
      end else if (spur_en && ($urandom_range(0, 49) == 0)) begin
        meas_done  = 1'b1;
        q_measured = 10'($urandom_range(0, 1023));
      end
      if (meas_start && resp_en) begin
        pend = 1'b1;
        pdly = $urandom_range(dly_lo, dly_hi);
        pq   = qfunc(qmode, int'(i_ref));
      end
    end
  end

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 sweeping, 2 found, 3 failed.  Within a sweep point,
  // t counts settle cycles; the measure slot is t==SETTLE.
  int m_mode, m_iref, m_opt, m_t, m_wcnt, m_lastq, m_currq;
  bit m_first, m_wait, m_eval, m_tmo;

  task automatic model_clear();
    m_mode = 0; m_iref = IMAX; m_opt = 0; m_t = 0; m_wcnt = 0;
    m_lastq = 0; m_currq = 0; m_first = 0; m_wait = 0; m_eval = 0; m_tmo = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || abort) begin
      model_clear();
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_iref = IMAX; m_first = 1; m_tmo = 0;
        m_t = 0; m_wait = 0; m_eval = 0;
      end
    end else if (m_eval) begin
      m_eval = 0;
      if (!m_first && (m_currq - m_lastq > DELTA)) begin
        m_mode = 2;
        m_opt  = (m_iref + BACKOFF * STEP > IMAX) ? IMAX : m_iref + BACKOFF * STEP;
      end else if (m_iref < STEP) begin
        m_mode = 3;
      end else begin
        m_iref  = m_iref - STEP;
        m_first = 0;
        m_t     = 0;
      end
    end else if (m_wait) begin
      if (meas_done) begin
        m_lastq = m_currq;
        m_currq = int'(q_measured);
        m_wait  = 0;
        m_eval  = 1;
      end else begin
        m_wcnt++;
        if (TMO_EN && (m_wcnt == TMO)) begin
          m_mode = 3; m_tmo = 1; m_wait = 0;
        end
      end
    end else if (m_t == SETTLE) begin
      m_wait = 1;
      m_wcnt = 0;
    end else begin
      m_t++;
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("i_ref",      32'(i_ref),      32'(m_iref));
      chk("i_ref_opt",  32'(i_ref_opt),  32'(m_opt));
      chk("busy",       32'(busy),       32'(m_mode == 1));
      chk("found",      32'(found),      32'(m_mode == 2));
      chk("fail",       32'(fail),       32'(m_mode == 3));
      chk("timeout",    32'(timeout),    32'(m_tmo));
      chk("meas_start", 32'(meas_start),
          32'((m_mode == 1) && !m_wait && !m_eval && (m_t == SETTLE)));
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic pulse_start(input int mode);
    @(negedge clk);
    qmode = mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int n = 0;
    while (!(found || fail) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(found | fail), 32'd1);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_i_ref", 32'(i_ref), 32'd1023);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_ms",    32'(meas_start), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Step change 100 -> 500 below 523: instability at 473.
    pulse_start(0);
    wait_end("end_s1");
    chk("s1_found", 32'(found),     32'd1);
    chk("s1_iref",  32'(i_ref),     32'd473);
    chk("s1_opt",   32'(i_ref_opt), 32'd573);

    // Reset pulsed mid-SETTLE of the second point, between clock edges.
    pulse_start(0);
    n = 0;
    while ((i_ref != 10'd973) && (n < 200)) begin @(negedge clk); n++; end
    chk("s_rst_reach973", 32'(i_ref), 32'd973);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_i_ref", 32'(i_ref),      32'd1023);
    chk("arst_opt",   32'(i_ref_opt),  32'd0);
    chk("arst_busy",  32'(busy),       32'd0);
    chk("arst_ms",    32'(meas_start), 32'd0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Q falls monotonically: sweep runs to the bottom and fails at 23.
    pulse_start(1);
    wait_end("end_s2");
    chk("s2_fail",  32'(fail),  32'd1);
    chk("s2_found", 32'(found), 32'd0);
    chk("s2_iref",  32'(i_ref), 32'd23);

    // Rise of exactly DELTA is not instability.
    pulse_start(2);
    wait_end("end_s3a");
    chk("s3a_found", 32'(found), 32'd0);
    chk("s3a_iref",  32'(i_ref), 32'd23);

    // Rise of DELTA+1 at 973: back-off saturates at full scale.
    pulse_start(3);
    wait_end("end_s3b");
    chk("s3b_found", 32'(found),     32'd1);
    chk("s3b_iref",  32'(i_ref),     32'd973);
    chk("s3b_opt",   32'(i_ref_opt), 32'd1023);

    // Abort while waiting for a measurement; the late meas_done must be ignored.
    dly_lo = 3; dly_hi = 3;
    pulse_start(0);
    n = 0;
    while (!meas_start && (n < 200)) begin @(negedge clk); n++; end
    chk("ab_saw_ms", 32'(meas_start), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_i_ref", 32'(i_ref),      32'd1023);
    chk("ab_busy",  32'(busy),       32'd0);
    chk("ab_ms",    32'(meas_start), 32'd0);
    repeat (8) @(negedge clk);
    chk("ab_still_idle", 32'(busy), 32'd0);
    dly_lo = 0; dly_hi = 4;

    // Measurement never returns.
    resp_en = 1'b0;
    pulse_start(0);
    if (TMO_EN) begin
      wait_end("end_tmo");
      chk("tmo_fail",    32'(fail),    32'd1);
      chk("tmo_timeout", 32'(timeout), 32'd1);
    end else begin
      repeat (120) @(negedge clk);
      chk("notmo_busy",    32'(busy),    32'd1);
      chk("notmo_timeout", 32'(timeout), 32'd0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    resp_en = 1'b1;

    // Randomized traffic: random Q patterns, starts (also while busy), aborts,
    // measurement delays and stray meas_done pulses.
    spur_en = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ((c % 400) == 0) qmode = $urandom_range(0, 4);
      start = ($urandom_range(0, 29) == 0);
      abort = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    spur_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
